uart_rx_cfg: RTL and testbench

//  Configurable UART receiver: successor to the fixed 8N1 receiver in the display-controller UART path.
//  - Compile-time data width, parity mode and stop-bit count.
//  - Glitch-rejecting start detection and 3-sample majority voting.
//  - Flags framing errors, parity errors and line breaks.
//  - Sits between the GPS/host serial pin and the command parser.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sampler.sv | 38 +++
 rtl/uart_rx_cfg.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and the majority helper.
// Shared with the future uart_tx_cfg.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE     = 3'd0,
    RX_START    = 3'd1,
    RX_DATA     = 3'd2,
    RX_PARITY   = 3'd3,
    RX_STOP     = 3'd4,
    RX_BRK_WAIT = 3'd5
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input conditioning for the UART receiver: 2-flop synchroniser, 3-tap window of the
// synchronised line, falling-edge detect and majority vote over the window.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_rxi,
  output logic o_rs,
  output logic o_fall_c,
  output logic o_maj_c
);

  logic r_meta;
  logic r_rs;
  logic r_rs_d1;
  logic r_rs_d2;

  // Reset to the idle-high level so no start edge is seen coming out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta  <= 1'b1;
      r_rs    <= 1'b1;
      r_rs_d1 <= 1'b1;
      r_rs_d2 <= 1'b1;
    end else begin
      r_meta  <= i_rxi;
      r_rs    <= r_meta;
      r_rs_d1 <= r_rs;
      r_rs_d2 <= r_rs_d1;
    end
  end

  assign o_rs     = r_rs;
  assign o_fall_c = r_rs_d1 & ~r_rs;
  assign o_maj_c  = maj3(r_rs, r_rs_d1, r_rs_d2);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: compile-time data width, parity and stop bits, with
// majority-voted sampling and framing/parity/break reporting.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned divisor   = 32,
  parameter int unsigned data_bits = 8,
  parameter int unsigned parity    = 0,
  parameter int unsigned stop_bits = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxi,
  output logic [data_bits-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(2 * divisor);
  localparam int unsigned BIT_W = $clog2(data_bits + 1);

  // The window completes one cycle after a bit centre, so the start decision lands on
  // count == divisor and later bits on a full-period wrap.
  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(divisor);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(2 * divisor - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(data_bits - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(stop_bits - 1);

  logic                 w_rs;
  logic                 w_fall;
  logic                 w_maj;
  logic                 w_centre;
  logic                 w_par_mismatch;
  logic                 w_is_break;

  rx_state_e            r_state;
  rx_state_e            w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [BIT_W-1:0]     r_bit;
  logic [BIT_W-1:0]     w_bit_nxt;
  logic [data_bits-1:0] r_shift;
  logic [data_bits-1:0] w_shift_nxt;
  logic [data_bits-1:0] r_data;
  logic [data_bits-1:0] w_data_nxt;
  logic                 r_par_bit;
  logic                 w_par_bit_nxt;
  logic                 r_perr;
  logic                 w_perr_nxt;
  logic                 r_ferr;
  logic                 w_ferr_nxt;
  logic                 r_valid;
  logic                 w_valid_nxt;
  logic                 r_perr_o;
  logic                 w_perr_o_nxt;
  logic                 r_ferr_o;
  logic                 w_ferr_o_nxt;
  logic                 r_brk;
  logic                 w_brk_nxt;
  logic                 r_busy;

  uart_rx_sampler u_sampler (
    .clk      (clk),
    .rst      (rst),
    .i_rxi    (rxi),
    .o_rs     (w_rs),
    .o_fall_c (w_fall),
    .o_maj_c  (w_maj)
  );

  assign w_centre = (r_cnt == FULL_CNT);

  // Odd parity wants the XOR of data and parity bit to be 1, even wants 0.
  assign w_par_mismatch = (parity == PARITY_ODD) ? ~(^{r_shift, w_maj}) : (^{r_shift, w_maj});

  assign w_is_break = (r_bit == BIT_W'(0)) && !w_maj && (r_shift == '0) &&
                      !((parity != PARITY_NONE) && r_par_bit);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = CNT_W'(r_cnt + 1'b1);
    w_bit_nxt     = r_bit;
    w_shift_nxt   = r_shift;
    w_data_nxt    = r_data;
    w_par_bit_nxt = r_par_bit;
    w_perr_nxt    = r_perr;
    w_ferr_nxt    = r_ferr;
    w_valid_nxt   = 1'b0;
    w_perr_o_nxt  = 1'b0;
    w_ferr_o_nxt  = 1'b0;
    w_brk_nxt     = 1'b0;

    unique case (r_state)
      RX_IDLE: begin
        w_cnt_nxt = '0;
        if (w_fall) begin
          w_state_nxt = RX_START;
          w_bit_nxt   = '0;
          w_perr_nxt  = 1'b0;
          w_ferr_nxt  = 1'b0;
        end
      end

      RX_START: begin
        if (r_cnt == HALF_CNT) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_maj ? RX_IDLE : RX_DATA;
        end
      end

      RX_DATA: begin
        if (w_centre) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_maj, r_shift[data_bits-1:1]};
          if (r_bit == DATA_LAST) begin
            w_bit_nxt   = '0;
            w_state_nxt = (parity != PARITY_NONE) ? RX_PARITY : RX_STOP;
          end else begin
            w_bit_nxt = BIT_W'(r_bit + 1'b1);
          end
        end
      end

      RX_PARITY: begin
        if (w_centre) begin
          w_cnt_nxt     = '0;
          w_par_bit_nxt = w_maj;
          w_perr_nxt    = w_par_mismatch;
          w_state_nxt   = RX_STOP;
        end
      end

      RX_STOP: begin
        if (w_centre) begin
          w_cnt_nxt = '0;
          if (w_is_break) begin
            w_brk_nxt   = 1'b1;
            w_state_nxt = RX_BRK_WAIT;
          end else begin
            w_ferr_nxt = r_ferr | ~w_maj;
            if (r_bit == STOP_LAST) begin
              w_valid_nxt  = 1'b1;
              w_data_nxt   = r_shift;
              w_perr_o_nxt = r_perr;
              w_ferr_o_nxt = r_ferr | ~w_maj;
              w_state_nxt  = RX_IDLE;
            end else begin
              w_bit_nxt = BIT_W'(r_bit + 1'b1);
            end
          end
        end
      end

      // Counter measures the current run of high cycles; any low sample restarts it.
      RX_BRK_WAIT: begin
        if (!w_rs) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == FULL_CNT) begin
          w_state_nxt = RX_IDLE;
        end
      end

      default: begin
        w_state_nxt = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_par_bit <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_valid   <= 1'b0;
      r_perr_o  <= 1'b0;
      r_ferr_o  <= 1'b0;
      r_brk     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_data    <= w_data_nxt;
      r_par_bit <= w_par_bit_nxt;
      r_perr    <= w_perr_nxt;
      r_ferr    <= w_ferr_nxt;
      r_valid   <= w_valid_nxt;
      r_perr_o  <= w_perr_o_nxt;
      r_ferr_o  <= w_ferr_o_nxt;
      r_brk     <= w_brk_nxt;
      r_busy    <= (w_state_nxt != RX_IDLE);
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign parity_err = r_perr_o;
  assign frame_err  = r_ferr_o;
  assign break_det  = r_brk;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: four receiver configurations driven with directed
// and random frames, checked against a frame-level reference model.
module tb_uart_rx_cfg;

  typedef struct {
    int         inst;
    logic       vld;
    logic       brk;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx [4];
  logic [7:0] d0, d1, d3;
  logic [6:0] d2;
  logic [3:0] v, pe, fe, bk, by;

  int  n_chk = 0;
  int  n_err = 0;
  ev_t evq[$];
  int  rd = 0;

  always #5 clk = ~clk;

  // inst0: 8N1 divisor 8 / inst1: 8N1 divisor 32 / inst2: 7O2 divisor 8 / inst3: 8E1 divisor 32
  uart_rx_cfg #(.divisor(8), .data_bits(8), .parity(0), .stop_bits(1)) u0 (
    .clk(clk), .rst(rst), .rxi(rx[0]), .data(d0), .valid(v[0]), .parity_err(pe[0]),
    .frame_err(fe[0]), .break_det(bk[0]), .busy(by[0]));
  uart_rx_cfg #(.divisor(32), .data_bits(8), .parity(0), .stop_bits(1)) u1 (
    .clk(clk), .rst(rst), .rxi(rx[1]), .data(d1), .valid(v[1]), .parity_err(pe[1]),
    .frame_err(fe[1]), .break_det(bk[1]), .busy(by[1]));
  uart_rx_cfg #(.divisor(8), .data_bits(7), .parity(1), .stop_bits(2)) u2 (
    .clk(clk), .rst(rst), .rxi(rx[2]), .data(d2), .valid(v[2]), .parity_err(pe[2]),
    .frame_err(fe[2]), .break_det(bk[2]), .busy(by[2]));
  uart_rx_cfg #(.divisor(32), .data_bits(8), .parity(2), .stop_bits(1)) u3 (
    .clk(clk), .rst(rst), .rxi(rx[3]), .data(d3), .valid(v[3]), .parity_err(pe[3]),
    .frame_err(fe[3]), .break_det(bk[3]), .busy(by[3]));

  // Record every cycle in which a completion or break pulse is visible.
  always @(negedge clk) begin
    if (v[0] || bk[0]) evq.push_back('{0, v[0], bk[0], 9'(d0), pe[0], fe[0]});
    if (v[1] || bk[1]) evq.push_back('{1, v[1], bk[1], 9'(d1), pe[1], fe[1]});
    if (v[2] || bk[2]) evq.push_back('{2, v[2], bk[2], 9'(d2), pe[2], fe[2]});
    if (v[3] || bk[3]) evq.push_back('{3, v[3], bk[3], 9'(d3), pe[3], fe[3]});
  end

  function automatic int bp_of(input int i);
    return (i == 0 || i == 2) ? 16 : 64;
  endfunction

  function automatic int nd_of(input int i);
    return (i == 2) ? 7 : 8;
  endfunction

  function automatic int pm_of(input int i);
    return (i == 2) ? 1 : (i == 3) ? 2 : 0;
  endfunction

  function automatic int ns_of(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  function automatic logic [8:0] mask_data(input int i, input logic [8:0] d);
    logic [8:0] m;
    m = (9'd1 << nd_of(i)) - 9'd1;
    return d & m;
  endfunction

  function automatic logic good_par(input int i, input logic [8:0] d);
    logic x;
    x = ^mask_data(i, d);
    return (pm_of(i) == 1) ? ~x : x;
  endfunction

  // Frame-level outcome: break when everything up to the first stop is low, otherwise a word.
  function automatic ev_t model(input int i, input logic [8:0] d, input logic pb,
                                input logic [1:0] stv);
    ev_t        e;
    logic [8:0] dm;
    dm     = mask_data(i, d);
    e.inst = i;
    e.data = dm;
    e.brk  = (dm == 9'd0) && (pm_of(i) == 0 || pb == 1'b0) && (stv[0] == 1'b0);
    e.vld  = !e.brk;
    e.perr = e.vld && (pm_of(i) != 0) && (((^dm) ^ pb) != (pm_of(i) == 1));
    e.ferr = e.vld && ((stv[0] == 1'b0) || (ns_of(i) == 2 && stv[1] == 1'b0));
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input int i, input logic b);
    rx[i] = b;
    idle(bp_of(i));
  endtask

  task automatic send_frame(input int i, input logic [8:0] d, input logic pb,
                            input logic [1:0] stv);
    drive_bit(i, 1'b0);
    for (int k = 0; k < nd_of(i); k++) drive_bit(i, d[k]);
    if (pm_of(i) != 0) drive_bit(i, pb);
    for (int k = 0; k < ns_of(i); k++) drive_bit(i, stv[k]);
    rx[i] = 1'b1;
  endtask

  task automatic check_event(input ev_t e, input string tag);
    int  waited;
    ev_t g;
    waited = 0;
    while (evq.size() <= rd && waited < 256) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_present"}, 32'(evq.size() > rd), 32'd1);
    if (evq.size() > rd) begin
      g = evq[rd];
      rd++;
      chk({tag, "_inst"},  32'(g.inst), 32'(e.inst));
      chk({tag, "_valid"}, 32'(g.vld),  32'(e.vld));
      chk({tag, "_break"}, 32'(g.brk),  32'(e.brk));
      chk({tag, "_perr"},  32'(g.perr), 32'(e.perr));
      chk({tag, "_ferr"},  32'(g.ferr), 32'(e.ferr));
      if (!e.brk) chk({tag, "_data"}, 32'(g.data), 32'(e.data));
    end
    chk({tag, "_no_extra"}, 32'(evq.size() == rd), 32'd1);
  endtask

  task automatic frame(input int i, input logic [8:0] d, input logic pb, input logic [1:0] stv,
                       input string tag);
    send_frame(i, d, pb, stv);
    idle(2 * bp_of(i));
    check_event(model(i, d, pb, stv), tag);
  endtask

  initial begin
    logic [8:0] rd_d;
    logic [1:0] rd_s;
    logic       rd_p;

    for (int i = 0; i < 4; i++) rx[i] = 1'b1;
    rst = 1'b1;
    idle(4);
    rst = 1'b0;
    idle(1);

    // Reset state
    chk("rst_busy",  32'(by), 32'd0);
    chk("rst_valid", 32'(v),  32'd0);
    chk("rst_perr",  32'(pe), 32'd0);
    chk("rst_ferr",  32'(fe), 32'd0);
    chk("rst_brk",   32'(bk), 32'd0);
    chk("rst_data",  32'({d0, d1, d2, d3}), 32'd0);

    // 7O2: reset in the middle of 0x33, then a clean 0x12
    drive_bit(2, 1'b0);
    drive_bit(2, 1'b1);
    drive_bit(2, 1'b1);
    drive_bit(2, 1'b0);
    rst   = 1'b1;
    rx[2] = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(3 * bp_of(2));
    chk("abort_no_event", 32'(evq.size() == rd), 32'd1);
    chk("abort_busy",     32'(by[2]), 32'd0);
    chk("abort_data",     32'(d2),    32'd0);
    frame(2, 9'h12, good_par(2, 9'h12), 2'b11, "t6_0x12");

    // 8E1 parity error and correct parity
    frame(3, 9'h5A, 1'b1, 2'b11, "t2_bad_par");
    frame(3, 9'h5A, good_par(3, 9'h5A), 2'b11, "t2_good_par");

    // 8N1 stop bit held low
    frame(1, 9'hC3, 1'b0, 2'b00, "t3_ferr");

    // Glitch shorter than half a bit
    rx[1] = 1'b0;
    idle(16);
    chk("t4_busy_during", 32'(by[1]), 32'd1);
    idle(14);
    rx[1] = 1'b1;
    idle(8);
    chk("t4_busy_after", 32'(by[1]), 32'd0);
    idle(64);
    chk("t4_no_event", 32'(evq.size() == rd), 32'd1);

    // Line break: 20 bit periods low, then a full bit high before idle
    rx[1] = 1'b0;
    idle(20 * 64);
    chk("t5_busy_low", 32'(by[1]), 32'd1);
    rx[1] = 1'b1;
    idle(60);
    chk("t5_busy_waiting", 32'(by[1]), 32'd1);
    idle(10);
    chk("t5_busy_released", 32'(by[1]), 32'd0);
    check_event(model(1, 9'h000, 1'b0, 2'b00), "t5_break");
    frame(1, 9'hA5, 1'b0, 2'b11, "t5_0xA5");

    // Every byte value on the fast 8N1 receiver
    for (int j = 0; j < 256; j++) frame(0, 9'(j), 1'b0, 2'b11, $sformatf("sweep_%0d", j));

    // Random frames with occasional stop and parity faults
    for (int n = 0; n < 6; n++) begin
      rd_d = 9'($urandom_range(0, 255));
      rd_s = {1'b1, ($urandom_range(0, 3) != 0)};
      frame(1, rd_d, 1'b0, rd_s, $sformatf("rnd8n1_%0d", n));
    end
    for (int n = 0; n < 6; n++) begin
      rd_d = 9'($urandom_range(0, 255));
      rd_p = good_par(3, rd_d) ^ 1'($urandom_range(0, 1));
      rd_s = {1'b1, ($urandom_range(0, 3) != 0)};
      frame(3, rd_d, rd_p, rd_s, $sformatf("rnd8e1_%0d", n));
    end
    for (int n = 0; n < 10; n++) begin
      rd_d = 9'($urandom_range(0, 127));
      rd_p = good_par(2, rd_d) ^ 1'($urandom_range(0, 1));
      rd_s = 2'($urandom_range(0, 3));
      frame(2, rd_d, rd_p, rd_s, $sformatf("rnd7o2_%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
